multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 8-bit core: drives fetch, decode, execute, memory and write-back over several cycles through one shared memory port with a req/ready handshake. Decodes the 2-bit mode and 2-bit opcode into the datapath control bundle, holds it stable for the whole instruction, issues write strobes only in the correct phase, and counts retired instructions. Sits between the instruction register, the shared memory port and the register file/ALU/PC datapath.

---
 rtl/seq_pkg.sv | 39 +++
 rtl/multicycle_sequencer_decode.sv | 22 ++
 rtl/multicycle_sequencer.sv | 168 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the multicycle instruction sequencer.
// Holds the state encoding, the mode/opcode constants, and the control
// bundle that is captured in DECODE and held for the rest of the instruction.
package seq_pkg;

  localparam int unsigned STALL_LIMIT_DEF = 15;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERROR
  } state_t;

  localparam logic [1:0] MODE_JUMP  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_STORE = 2'b10;
  localparam logic [1:0] MODE_ALU   = 2'b11;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_IMM = 2'b11;

  // Decoded control bundle, held stable from EXEC through retire
  typedef struct packed {
    logic [1:0] mode;
    logic       reg_we;         // ALU op that writes the register file
    logic       val_a_imm;
    logic       val_b_pc;
    logic       val_b_imm;
    logic       alu_neg;
    logic       reg_num_shift;
  } ctrl_t;

endpackage

// File: rtl/multicycle_sequencer_decode.sv
// Combinational instruction decoder: mode/opcode fields -> ctrl_t bundle.
// Ports: i_mode, i_opcode (instruction fields), o_ctrl (decoded bundle).
module seq_decode
  import seq_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [1:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl               = '0;
    o_ctrl.mode          = i_mode;
    o_ctrl.reg_we        = (i_mode == MODE_ALU) && (i_opcode != OP_NOP);
    o_ctrl.val_a_imm     = (i_mode != MODE_ALU);
    o_ctrl.val_b_pc      = (i_mode == MODE_JUMP);
    o_ctrl.val_b_imm     = (i_mode == MODE_ALU) && (i_opcode == OP_IMM);
    o_ctrl.alu_neg       = (i_mode == MODE_ALU) && (i_opcode == OP_SUB);
    o_ctrl.reg_num_shift = (i_mode == MODE_LOAD) || (i_mode == MODE_STORE);
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the 8-bit core: FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port with req/ready handshake, memory stall timeout, and a
// wrapping retired-instruction counter.
// Ports: clk, reset (async, active-high); run, instr_mode, instr_opcode,
// mem_ready in; memory strobes, datapath strobes, operand selects, busy,
// timeout (sticky) and instr_count out.
// Optional: SEQ_SINGLE_STEP_EN adds input step, which starts one instruction
// from IDLE while run is low.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       instr_mode,
  input  logic [1:0]       instr_opcode,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_write,
  output logic             register_write,
  output logic             memory_to_register,
  output logic             alu_negation,
  output logic             val_a_imm_selection,
  output logic             val_b_pc_selection,
  output logic             val_b_imm_selection,
  output logic             reg_num_shift,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;

  state_t            r_state;
  state_t            w_next;
  ctrl_t             r_ctrl;
  ctrl_t             w_ctrl;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_count;
  logic              r_timeout;
  logic              w_retire;
  logic              w_start;
  logic              w_at_limit;
  logic              w_sel_en;

  seq_decode u_decode (
    .i_mode   (instr_mode),
    .i_opcode (instr_opcode),
    .o_ctrl   (w_ctrl)
  );

`ifdef SEQ_SINGLE_STEP_EN
  assign w_start = run | step;
`else
  assign w_start = run;
`endif

  // Current stall cycle is the last one tolerated; a ready in this cycle still wins
  assign w_at_limit = (STALL_LIMIT != 0) && (32'(r_wait) == (STALL_LIMIT - 1));

  assign w_sel_en = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);

  // Next-state and strobe decode
  always_comb begin
    w_next              = r_state;
    w_retire            = 1'b0;
    mem_req             = 1'b0;
    mem_we              = 1'b0;
    mem_addr_sel        = 1'b0;
    ir_write            = 1'b0;
    pc_inc              = 1'b0;
    pc_write            = 1'b0;
    register_write      = 1'b0;
    memory_to_register  = 1'b0;
    alu_negation        = w_sel_en & r_ctrl.alu_neg;
    val_a_imm_selection = w_sel_en & r_ctrl.val_a_imm;
    val_b_pc_selection  = w_sel_en & r_ctrl.val_b_pc;
    val_b_imm_selection = w_sel_en & r_ctrl.val_b_imm;
    reg_num_shift       = w_sel_en & r_ctrl.reg_num_shift;
    busy                = (r_state != ST_IDLE) && (r_state != ST_ERROR);

    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_at_limit) begin
          w_next = ST_ERROR;
        end
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        case (r_ctrl.mode)
          MODE_JUMP: begin
            pc_write = 1'b1;
            w_retire = 1'b1;
          end
          MODE_LOAD, MODE_STORE: w_next = ST_MEM;
          default: begin
            register_write = r_ctrl.reg_we;
            w_retire       = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (r_ctrl.mode == MODE_STORE);
        if (mem_ready) begin
          if (r_ctrl.mode == MODE_STORE) w_retire = 1'b1;
          else                           w_next   = ST_WB;
        end else if (w_at_limit) begin
          w_next = ST_ERROR;
        end
      end
      ST_WB: begin
        register_write     = 1'b1;
        memory_to_register = 1'b1;
        w_retire           = 1'b1;
      end
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_IDLE;
    endcase

    // run is only sampled here and in IDLE, so dropping it never aborts
    if (w_retire) w_next = run ? ST_FETCH : ST_IDLE;
  end

  // State, captured control, stall counter, retire counter, sticky timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_wait    <= '0;
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_ctrl <= w_ctrl;
      // Staying in a memory state means this was a stall cycle; any transition clears
      if (((r_state == ST_FETCH) || (r_state == ST_MEM)) && (w_next == r_state))
        r_wait <= r_wait + WAIT_W'(1);
      else
        r_wait <= '0;
      if (w_retire) r_count <= r_count + CNT_W'(1);
      if ((w_next == ST_ERROR) && (r_state != ST_ERROR)) r_timeout <= 1'b1;
    end
  end

  assign timeout     = r_timeout;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the driver expands each
// instruction into its per-cycle output pattern and queues it; the monitor
// pops and compares one entry per cycle on the falling edge.
module tb_multicycle_sequencer;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LIMIT = 15;

  // Bit positions in the observed output vector
  localparam int B_REQ = 14, B_WE = 13, B_AS = 12, B_IRW = 11, B_PCI = 10,
                 B_PCW = 9, B_RW = 8, B_M2R = 7, B_NEG = 6, B_VA = 5,
                 B_VBPC = 4, B_VBIMM = 3, B_RNS = 2, B_BUSY = 1, B_TO = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic [1:0] instr_mode = 2'b00;
  logic [1:0] instr_opcode = 2'b00;
  logic step = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_we, mem_addr_sel, ir_write, pc_inc, pc_write;
  logic register_write, memory_to_register, alu_negation;
  logic val_a_imm_selection, val_b_pc_selection, val_b_imm_selection, reg_num_shift;
  logic busy, timeout;
  logic [CNT_W-1:0] instr_count;
  logic [14:0] obs;

  multicycle_sequencer #(.STALL_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run),
    .instr_mode(instr_mode), .instr_opcode(instr_opcode),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_inc(pc_inc), .pc_write(pc_write),
    .register_write(register_write), .memory_to_register(memory_to_register),
    .alu_negation(alu_negation), .val_a_imm_selection(val_a_imm_selection),
    .val_b_pc_selection(val_b_pc_selection), .val_b_imm_selection(val_b_imm_selection),
    .reg_num_shift(reg_num_shift), .busy(busy), .timeout(timeout),
    .instr_count(instr_count)
  );

  assign obs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_inc, pc_write,
                register_write, memory_to_register, alu_negation,
                val_a_imm_selection, val_b_pc_selection, val_b_imm_selection,
                reg_num_shift, busy, timeout};

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] v;
    logic [7:0]  c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  bit   in_idle = 1'b1;

  // Monitor: one expected entry per driven cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v || instr_count !== e.c) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t: got %b cnt=%0d, expected %b cnt=%0d",
                   $time, obs, instr_count, e.v, e.c);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] bitv(input int b);
    logic [14:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Operand selects straight from the instruction-set definition
  function automatic logic [14:0] sels(input logic [1:0] m, input logic [1:0] op);
    logic [14:0] v;
    v = '0;
    v[B_VA]    = (m != 2'b11);
    v[B_VBPC]  = (m == 2'b00);
    v[B_VBIMM] = (m == 2'b11) && (op == 2'b11);
    v[B_NEG]   = (m == 2'b11) && (op == 2'b10);
    v[B_RNS]   = (m == 2'b01) || (m == 2'b10);
    return v;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic r, input logic rdy, input logic st,
                     input logic [14:0] v, input bit retire);
    exp_t e;
    @(posedge clk);
    #1;
    run = r;
    mem_ready = rdy;
    step = st;
    e.v = v;
    e.c = 8'(exp_cnt);
    q.push_back(e);
    if (retire) exp_cnt++;
  endtask

  task automatic error_cycles();
    for (int i = 0; i < 3; i++) cyc(rnd(), rnd(), 1'b0, bitv(B_TO), 1'b0);
  endtask

  task automatic check_direct(input string name, input logic [14:0] v, input logic [7:0] c);
    checks++;
    if (obs !== v || instr_count !== c) begin
      errors++;
      $display("FAIL %s: got %b cnt=%0d, expected %b cnt=%0d", name, obs, instr_count, v, c);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2;
    reset = 1'b1;
    run = 1'b0;
    mem_ready = 1'b0;
    step = 1'b0;
    #1;
    check_direct("reset_async", '0, 8'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_cnt = 0;
    in_idle = 1'b1;
  endtask

  // One instruction; fw/mw are stall cycles before ready (>= LIMIT means timeout)
  task automatic run_instr(input logic [1:0] m, input logic [1:0] op,
                           input int fw, input int mw, input logic run_after);
    logic [14:0] b, s, mv;
    b = bitv(B_BUSY);
    s = sels(m, op) | b;
    instr_mode = m;
    instr_opcode = op;
    if (in_idle) begin
      cyc(1'b1, rnd(), 1'b0, '0, 1'b0);
      in_idle = 1'b0;
    end
    for (int i = 0; i < fw && i < int'(LIMIT); i++) cyc(rnd(), 1'b0, 1'b0, b | bitv(B_REQ), 1'b0);
    if (fw >= int'(LIMIT)) begin
      error_cycles();
      return;
    end
    cyc(rnd(), 1'b1, 1'b0, b | bitv(B_REQ) | bitv(B_IRW) | bitv(B_PCI), 1'b0);
    cyc(rnd(), rnd(), 1'b0, b, 1'b0);
    if (m == 2'b00) begin
      cyc(run_after, rnd(), 1'b0, s | bitv(B_PCW), 1'b1);
    end else if (m == 2'b11) begin
      cyc(run_after, rnd(), 1'b0, (op != 2'b00) ? (s | bitv(B_RW)) : s, 1'b1);
    end else begin
      cyc(rnd(), rnd(), 1'b0, s, 1'b0);
      mv = s | bitv(B_REQ) | bitv(B_AS) | ((m == 2'b10) ? bitv(B_WE) : 15'd0);
      for (int i = 0; i < mw && i < int'(LIMIT); i++) cyc(rnd(), 1'b0, 1'b0, mv, 1'b0);
      if (mw >= int'(LIMIT)) begin
        error_cycles();
        return;
      end
      if (m == 2'b10) begin
        cyc(run_after, 1'b1, 1'b0, mv, 1'b1);
      end else begin
        cyc(rnd(), 1'b1, 1'b0, mv, 1'b0);
        cyc(run_after, rnd(), 1'b0, s | bitv(B_RW) | bitv(B_M2R), 1'b1);
      end
    end
    in_idle = !run_after;
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 9) return int'(LIMIT) - 1;
    return r % 4;
  endfunction

  initial begin
    reset_dut();
    // IDLE holds with run low
    cyc(1'b0, rnd(), 1'b0, '0, 1'b0);
    cyc(1'b0, rnd(), 1'b0, '0, 1'b0);

    // Directed: ALU op 01, load with 2 memory waits, store, jump, then stop
    run_instr(2'b11, 2'b01, 0, 0, 1'b1);
    run_instr(2'b01, 2'b00, 0, 2, 1'b1);
    run_instr(2'b10, 2'b11, 1, 0, 1'b1);
    run_instr(2'b00, 2'b10, 0, 0, 1'b0);
    cyc(1'b0, rnd(), 1'b0, '0, 1'b0);

    // Ready arrives on the last tolerated stall cycle in FETCH and in MEM
    run_instr(2'b11, 2'b10, int'(LIMIT) - 1, 0, 1'b1);
    run_instr(2'b01, 2'b01, 0, int'(LIMIT) - 1, 1'b0);

    // Random instruction mix
    for (int n = 0; n < 200; n++) begin
      run_instr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                pick_wait(), pick_wait(), ($urandom_range(0, 9) != 0));
    end
    if (!in_idle) run_instr(2'b11, 2'b00, 0, 0, 1'b0);

    // Timeout in FETCH, then in MEM
    reset_dut();
    run_instr(2'b11, 2'b01, int'(LIMIT), 0, 1'b1);
    reset_dut();
    run_instr(2'b10, 2'b00, 0, int'(LIMIT), 1'b1);
    reset_dut();

    // 256 NOPs wrap the counter back to zero
    for (int n = 0; n < 256; n++) run_instr(2'b11, 2'b00, 0, 0, (n != 255));
    cyc(1'b0, rnd(), 1'b0, '0, 1'b0);

    // Reset asserted in the middle of a stalled MEM access
    run_instr(2'b11, 2'b11, 0, 0, 1'b1);
    instr_mode = 2'b01;
    instr_opcode = 2'b00;
    cyc(1'b1, 1'b1, 1'b0, bitv(B_BUSY) | bitv(B_REQ) | bitv(B_IRW) | bitv(B_PCI), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, bitv(B_BUSY), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, sels(2'b01, 2'b00) | bitv(B_BUSY), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, sels(2'b01, 2'b00) | bitv(B_BUSY) | bitv(B_REQ) | bitv(B_AS), 1'b0);
    reset_dut();
    cyc(1'b0, rnd(), 1'b0, '0, 1'b0);

`ifdef SEQ_SINGLE_STEP_EN
    // One step pulse with run low: exactly one instruction, then IDLE
    instr_mode = 2'b01;
    instr_opcode = 2'b10;
    cyc(1'b0, rnd(), 1'b1, '0, 1'b0);
    in_idle = 1'b0;
    run_instr(2'b01, 2'b10, 1, 1, 1'b0);
    cyc(1'b0, rnd(), 1'b0, '0, 1'b0);
    cyc(1'b0, rnd(), 1'b0, '0, 1'b0);
`endif

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
